// File: rtl/move_batcher.sv
// Packs accepted 4-bit move codes into a 50-slot batch word for the cube-state
// update stage, cancelling adjacent inverse pairs and holding each batch until applied.
module move_batcher #(
  parameter int MAX_MOVES = 50,
  parameter int MOVE_W    = 4,
  parameter bit CANCEL_EN = 1'b1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [MOVE_W-1:0]             move_in,
  input  logic                          move_valid,
  output logic                          move_ready,
  input  logic                          flush,
  input  logic                          state_updated,
  output logic [MAX_MOVES*MOVE_W-1:0]   moves,
  output logic                          new_moves_ready,
  output logic [5:0]                    count,
  output logic                          busy,
  output logic                          drop_err
);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [MAX_MOVES*MOVE_W-1:0]   moves_q, moves_d;
  logic [5:0]                    count_q, count_d;
  logic                          nmr_q, nmr_d;
  logic                          busy_q, busy_d;
  logic                          drop_q, drop_d;

  logic                          accept_s;
  logic                          illegal_s;
  logic                          cancel_s;
  logic [MOVE_W-1:0]             last_s;
  int                            app_base_s;
  int                            last_base_s;

  assign move_ready = (state_q == ST_FILL) && (count_q < 6'(MAX_MOVES));
  assign accept_s   = move_valid && move_ready;
  assign illegal_s  = (move_in == MOVE_W'(1)) || (move_in == MOVE_W'(14)) ||
                      (move_in == MOVE_W'(15));

  // Slot k lives at the top of the word so slot 0 is the most significant nibble.
  always_comb begin
    app_base_s  = (MAX_MOVES - 1 - int'(count_q)) * MOVE_W;
    last_base_s = 0;
    if (count_q != 6'd0) begin
      last_base_s = (MAX_MOVES - int'(count_q)) * MOVE_W;
    end else begin
      last_base_s = 0;
    end
    if (count_q != 6'd0) begin
      last_s = moves_q[last_base_s +: MOVE_W];
    end else begin
      last_s = '0;
    end
    cancel_s = CANCEL_EN && (count_q != 6'd0) &&
               (move_in[MOVE_W-1:1] == last_s[MOVE_W-1:1]) &&
               (move_in[0] != last_s[0]);
  end

  always_comb begin
    state_d = state_q;
    moves_d = moves_q;
    count_d = count_q;
    nmr_d   = 1'b0;
    busy_d  = busy_q;
    drop_d  = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (accept_s) begin
          if (move_in == '0) begin
            moves_d = moves_q;
          end else if (illegal_s) begin
            drop_d = 1'b1;
          end else if (cancel_s) begin
            moves_d[last_base_s +: MOVE_W] = '0;
            count_d = count_q - 6'd1;
          end else begin
            moves_d[app_base_s +: MOVE_W] = move_in;
            count_d = count_q + 6'd1;
          end
        end else begin
          moves_d = moves_q;
        end
        // Flush is judged on the count after this cycle's move has been applied.
        if ((count_d == 6'(MAX_MOVES)) || (flush && (count_d != 6'd0))) begin
          state_d = ST_ISSUE;
          nmr_d   = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        busy_d  = 1'b1;
      end
      ST_WAIT: begin
        if (state_updated) begin
          state_d = ST_FILL;
          moves_d = '0;
          count_d = 6'd0;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_FILL;
        moves_d = '0;
        count_d = 6'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FILL;
      moves_q <= '0;
      count_q <= 6'd0;
      nmr_q   <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      moves_q <= moves_d;
      count_q <= count_d;
      nmr_q   <= nmr_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  assign moves           = moves_q;
  assign count           = count_q;
  assign new_moves_ready = nmr_q;
  assign busy            = busy_q;
  assign drop_err        = drop_q;

endmodule
